ram_req_adapter: RTL

RAM_REQ_ADAPTER -- requirements
Module: ram_req_adapter

---
 rtl/ram_pkg.sv | 12 +
 rtl/rsp_fifo.sv | 61 ++++++
 rtl/ram_req_adapter.sv | 79 +++++++
 3 files changed

// File: rtl/ram_pkg.sv
// Shared constants and sizing helpers for the RAM request adapter and its
// response buffer.
package ram_pkg;

  localparam int RSP_DEPTH_MIN = 3;

  // Bits needed to hold an occupancy value from 0 up to and including depth.
  function automatic int occ_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/rsp_fifo.sv
// Register-based response FIFO with circular pointers that wrap modulo DEPTH
// and an explicit entry count.
module rsp_fifo
  import ram_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3,
  localparam int CNT_W = occ_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_pushData,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_headData,
  output logic [CNT_W-1:0] o_count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wrPtr;
  logic [PTR_W-1:0] r_rdPtr;
  logic [CNT_W-1:0] r_count;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (i_push) r_wrPtr <= nextPtr(r_wrPtr);
      if (i_pop)  r_rdPtr <= nextPtr(r_rdPtr);
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; only the pointers and count decide what is valid.
  always_ff @(posedge clk) begin
    if (i_push) r_mem[r_wrPtr] <= i_pushData;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(i_pop && (r_count == '0)));
      assert (!(i_push && (r_count == CNT_W'(DEPTH))));
    end
  end

  assign o_headData = r_mem[r_rdPtr];
  assign o_count    = r_count;

endmodule

// File: rtl/ram_req_adapter.sv
// Adapts a valid/ready request stream onto a single-port RAM with one-cycle
// registered read data, buffering read responses in order.
module ram_req_adapter
  import ram_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 11,
  parameter int RSP_DEPTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_BITS-1:0] req_addr,
  input  logic [WIDTH-1:0]     req_wdata,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [WIDTH-1:0]     rsp_data,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_addr,
  output logic [WIDTH-1:0]     ram_wdata,
  input  logic [WIDTH-1:0]     ram_rdata,
  output logic                 busy
);

  generate
    if (RSP_DEPTH < RSP_DEPTH_MIN) begin : g_depthCheck
      $error("ram_req_adapter: RSP_DEPTH must be at least 3");
    end
  endgenerate

  localparam int OCC_W = occ_width(RSP_DEPTH);
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(RSP_DEPTH);

  logic             r_inFlight;
  logic [OCC_W-1:0] w_count;
  logic [OCC_W-1:0] w_occupancy;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;

  // Counting the in-flight read reserves its buffer slot before the data lands,
  // so a push can never meet a full FIFO.
  assign w_occupancy = w_count + OCC_W'(r_inFlight);
  assign req_ready   = !rst && (w_occupancy < DEPTH_OCC);
  assign w_accept    = req_valid && req_ready;

  assign ram_we    = w_accept && req_we;
  assign ram_addr  = req_addr;
  assign ram_wdata = req_wdata;

  assign rsp_valid = !rst && (w_count != '0);
  assign busy      = !rst && (w_occupancy != '0);
  assign w_push    = r_inFlight && !rst;
  assign w_pop     = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_inFlight <= 1'b0;
    end else begin
      r_inFlight <= w_accept && !req_we;
    end
  end

  rsp_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (RSP_DEPTH)
  ) u_rspFifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_pushData (ram_rdata),
    .i_pop      (w_pop),
    .o_headData (rsp_data),
    .o_count    (w_count)
  );

endmodule
